// File: rtl/vt100_seq_encoder.sv
`default_nettype none
// ============================================================================
// Module   : vt100_seq_encoder
// Brief    : Serialises key/report requests into VT100 byte sequences over a
//            valid/ready byte port. Optional macro APP_CURSOR_EN enables
//            application cursor-key mode (ESC O x).
// Revision : 1.0 - initial release
// ============================================================================
module vt100_seq_encoder #(
   parameter int DA_CLASS = 1,
   parameter int DA_OPTS  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_cmd,
   input  logic [7:0] req_pn1,
   input  logic [7:0] req_pn2,
   input  logic       app_cursor,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready
);

   localparam logic [2:0] c_CMD_CHAR  = 3'd0;
   localparam logic [2:0] c_CMD_LEFT  = 3'd4;
   localparam logic [2:0] c_CMD_CPR   = 3'd5;
   localparam logic [2:0] c_CMD_DA    = 3'd6;
   localparam logic [2:0] c_CMD_DSR   = 3'd7;

   localparam logic [7:0] c_ESC       = 8'h1B;
   localparam logic [7:0] c_CSI       = 8'h5B;
   localparam logic [7:0] c_SS3       = 8'h4F;
   localparam logic [7:0] c_QMARK     = 8'h3F;
   localparam logic [7:0] c_SEMI      = 8'h3B;
   localparam logic [7:0] c_ZERO      = 8'h30;
   localparam logic [7:0] c_DA_CLASS  = 8'h30 + 8'(DA_CLASS);
   localparam logic [7:0] c_DA_OPTS   = 8'h30 + 8'(DA_OPTS);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ESC   = 4'd1,
      S_INTRO = 4'd2,
      S_QMARK = 4'd3,
      S_NUM1  = 4'd4,
      S_SEMI  = 4'd5,
      S_NUM2  = 4'd6,
      S_FINAL = 4'd7,
      S_RAW   = 4'd8
   } state_t;

   state_t     r_state;
   logic [1:0] r_idx;
   logic [2:0] r_cmd;
   logic [7:0] r_pn1;
   logic [7:0] r_pn2;
   logic       r_app;
   logic       r_ready;
   logic [7:0] r_tx_data;
   logic       r_tx_valid;

   state_t     w_nstate;
   logic [1:0] w_nidx;
   logic [7:0] w_nbyte;
   logic [1:0] w_n1;
   logic [1:0] w_n2;
   logic       w_is_key;

   // Number of decimal digits with leading zeros suppressed (1..3).
   function automatic logic [1:0] dec_len(input logic [7:0] v);
      if (v >= 8'd100)
         return 2'd3;
      else if (v >= 8'd10)
         return 2'd2;
      else
         return 2'd1;
   endfunction

   // ASCII digit idx (0 = most significant emitted digit) of v.
   function automatic logic [7:0] dec_digit(input logic [7:0] v, input logic [1:0] idx);
      logic [7:0] hund;
      logic [7:0] rem;
      logic [7:0] tens;
      logic [7:0] sel;
      logic [1:0] pos;
      hund = (v >= 8'd200) ? 8'd2 : ((v >= 8'd100) ? 8'd1 : 8'd0);
      rem  = v - hund * 8'd100;
      tens = 8'd0;
      for (int k = 1; k < 10; k++) begin
         if (rem >= 8'(k * 10))
            tens = 8'(k);
      end
      pos = idx + (2'd3 - dec_len(v));
      case (pos)
         2'd0:    sel = hund;
         2'd1:    sel = tens;
         default: sel = rem - tens * 8'd10;
      endcase
      return c_ZERO + sel;
   endfunction

   assign w_is_key = (req_cmd != c_CMD_CHAR) && (req_cmd <= c_CMD_LEFT);
   assign w_n1     = (r_cmd == c_CMD_CPR) ? dec_len(r_pn1) : 2'd1;
   assign w_n2     = (r_cmd == c_CMD_CPR) ? dec_len(r_pn2) : 2'd1;

   always_comb begin
      w_nstate = S_IDLE;
      w_nidx   = 2'd0;
      case (r_state)
         S_ESC:   w_nstate = S_INTRO;
         S_INTRO: begin
            case (r_cmd)
               c_CMD_CPR, c_CMD_DSR: w_nstate = S_NUM1;
               c_CMD_DA:             w_nstate = S_QMARK;
               default:              w_nstate = S_FINAL;
            endcase
         end
         S_QMARK: w_nstate = S_NUM1;
         S_NUM1: begin
            if (r_idx + 2'd1 < w_n1) begin
               w_nstate = S_NUM1;
               w_nidx   = r_idx + 2'd1;
            end else if (r_cmd == c_CMD_DSR) begin
               w_nstate = S_FINAL;
            end else begin
               w_nstate = S_SEMI;
            end
         end
         S_SEMI:  w_nstate = S_NUM2;
         S_NUM2: begin
            if (r_idx + 2'd1 < w_n2) begin
               w_nstate = S_NUM2;
               w_nidx   = r_idx + 2'd1;
            end else begin
               w_nstate = S_FINAL;
            end
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   always_comb begin
      w_nbyte = 8'h00;
      case (w_nstate)
         S_ESC:   w_nbyte = c_ESC;
         S_INTRO: w_nbyte = r_app ? c_SS3 : c_CSI;
         S_QMARK: w_nbyte = c_QMARK;
         S_NUM1: begin
            case (r_cmd)
               c_CMD_CPR: w_nbyte = dec_digit(r_pn1, w_nidx);
               c_CMD_DA:  w_nbyte = c_DA_CLASS;
               default:   w_nbyte = c_ZERO;
            endcase
         end
         S_SEMI:  w_nbyte = c_SEMI;
         S_NUM2:  w_nbyte = (r_cmd == c_CMD_CPR) ? dec_digit(r_pn2, w_nidx) : c_DA_OPTS;
         S_FINAL: begin
            case (r_cmd)
               c_CMD_CPR: w_nbyte = 8'h52;
               c_CMD_DA:  w_nbyte = 8'h63;
               c_CMD_DSR: w_nbyte = 8'h6E;
               default:   w_nbyte = 8'h40 + {5'd0, r_cmd};
            endcase
         end
         S_RAW:   w_nbyte = r_pn1;
         default: w_nbyte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= 2'd0;
         r_cmd      <= 3'd0;
         r_pn1      <= 8'h00;
         r_pn2      <= 8'h00;
         r_app      <= 1'b0;
         r_ready    <= 1'b1;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (req_valid && r_ready) begin
            r_cmd      <= req_cmd;
            r_pn1      <= req_pn1;
            r_pn2      <= req_pn2;
`ifdef APP_CURSOR_EN
            r_app      <= app_cursor && w_is_key;
`else
            r_app      <= 1'b0;
`endif
            r_idx      <= 2'd0;
            r_ready    <= 1'b0;
            r_tx_valid <= 1'b1;
            // First byte is known from the request itself, giving 1-cycle latency.
            if (req_cmd == c_CMD_CHAR) begin
               r_state   <= S_RAW;
               r_tx_data <= req_pn1;
            end else begin
               r_state   <= S_ESC;
               r_tx_data <= c_ESC;
            end
         end
      end else if (r_tx_valid && tx_ready) begin
         r_state    <= w_nstate;
         r_idx      <= w_nidx;
         r_tx_data  <= w_nbyte;
         r_tx_valid <= (w_nstate != S_IDLE);
         r_ready    <= (w_nstate == S_IDLE);
      end
   end

`ifndef APP_CURSOR_EN
   logic w_unused_app;
   assign w_unused_app = app_cursor ^ w_is_key;
`endif

   assign req_ready = r_ready;
   assign tx_data   = r_tx_data;
   assign tx_valid  = r_tx_valid;

endmodule
`default_nettype wire
